// File: rtl/instr_fetch_buffer_pkg.sv
// Shared types and constants for the instruction fetch buffer.
package fetch_pkg;

    // Default number of buffered fetch entries.
    localparam int IFB_DEPTH_DEFAULT = 4;

    // One buffered fetch: PC, raw instruction word and the alignment flag
    // captured when the entry was accepted.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        misalign;
    } fetch_entry_t;

    // A PC is misaligned when either of its two low bits is set.
    function automatic logic pc_misaligned(input logic [31:0] pc);
        return (pc[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/instr_fetch_buffer_if.sv
// Fetch-side and decode-side handshake bundle for the instruction fetch buffer.
//
// Handshake rules (both sides): a transfer happens on a rising clock edge
// where valid and ready are both high. Once valid is raised the producer
// holds its payload stable until the transfer completes (except when a flush
// discards it). Ready never depends combinationally on the same-cycle valid.
interface instr_fetch_buffer_if;

    // Fetch stage -> buffer
    logic        fetch_valid_i;
    logic [31:0] fetch_pc_i;
    logic [31:0] fetch_instr_i;
    logic        fetch_ready_o;

    // Buffer -> decode stage
    logic        dec_valid_o;
    logic        dec_ready_i;
    logic [31:0] dec_pc_o;
    logic [31:0] dec_instr_o;
    logic        dec_misalign_o;

    // Environment side: drives fetch payload and decode ready.
    modport master (
        output fetch_valid_i,
        output fetch_pc_i,
        output fetch_instr_i,
        input  fetch_ready_o,
        input  dec_valid_o,
        output dec_ready_i,
        input  dec_pc_o,
        input  dec_instr_o,
        input  dec_misalign_o
    );

    // Buffer side.
    modport slave (
        input  fetch_valid_i,
        input  fetch_pc_i,
        input  fetch_instr_i,
        output fetch_ready_o,
        output dec_valid_o,
        input  dec_ready_i,
        output dec_pc_o,
        output dec_instr_o,
        output dec_misalign_o
    );

endinterface

// File: rtl/instr_fetch_buffer.sv
// Instruction fetch buffer: small FIFO between fetch and decode with
// redirect flush. No fall-through: an accepted entry is visible to decode
// from the cycle after acceptance. Full/empty come from the occupancy count.
module instr_fetch_buffer
    import fetch_pkg::*;
#(
    parameter int DEPTH = IFB_DEPTH_DEFAULT
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    instr_fetch_buffer_if.slave      bus,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Only powers of two from 2 to 16 are supported; pointer wrap relies on it.
    if ((DEPTH < 2) || (DEPTH > 16) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("instr_fetch_buffer: DEPTH must be a power of two from 2 to 16");
    end

    fetch_entry_t            mem [DEPTH];
    fetch_entry_t            head;
    fetch_entry_t            wr_entry;
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
    logic [CNT_W-1:0]        count;
    logic                    full;
    logic                    empty;
    logic                    push;
    logic                    pop;

    // Occupancy-derived status; ready depends only on registered state.
    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    assign bus.fetch_ready_o = !full;
    assign bus.dec_valid_o   = !empty && !flush_i;

    // A flush swallows any concurrent push; pop is already blocked by valid.
    assign push = bus.fetch_valid_i && !full && !flush_i;
    assign pop  = bus.dec_valid_o && bus.dec_ready_i;

    // Alignment is decided once, at acceptance, and travels with the entry.
    assign wr_entry.pc       = bus.fetch_pc_i;
    assign wr_entry.instr    = bus.fetch_instr_i;
    assign wr_entry.misalign = pc_misaligned(bus.fetch_pc_i);

    // Pointer and count state; async reset and flush both return to empty.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage; contents are qualified by count so need no reset.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    // Head entry drives decode; fields are don't-care while dec_valid_o is low.
    assign head               = mem[rd_ptr];
    assign bus.dec_pc_o       = head.pc;
    assign bus.dec_instr_o    = head.instr;
    assign bus.dec_misalign_o = head.misalign;

    assign count_o = count;

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Directed self-checking bench for instr_fetch_buffer (DEPTH = 4).
// Inputs change and outputs are observed around the falling clock edge.
module tb_instr_fetch_buffer;

    localparam int DEPTH = 4;

    logic       clk_i;
    logic       rst_ni;
    logic       flush_i;
    logic [2:0] count_o;

    int n_checks;
    int n_fail;

    logic [31:0] exp_q[$];
    logic [31:0] exp_pc;

    instr_fetch_buffer_if bus ();

    instr_fetch_buffer #(.DEPTH(DEPTH)) dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (flush_i),
        .bus     (bus),
        .count_o (count_o)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return pc ^ 32'h1357_0013;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive(input logic v, input logic [31:0] pc, input logic rdy, input logic fl);
        @(negedge clk_i);
        bus.fetch_valid_i = v;
        bus.fetch_pc_i    = pc;
        bus.fetch_instr_i = instr_of(pc);
        bus.dec_ready_i   = rdy;
        flush_i           = fl;
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_ni = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        n_checks++; if (count_o !== 3'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", count_o); end
        n_checks++; if (bus.dec_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_dec_valid got=%b exp=0", bus.dec_valid_o); end
        n_checks++; if (bus.fetch_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_fetch_ready got=%b exp=1", bus.fetch_ready_o); end
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    task automatic test_single();
        // Push PC 0 on the first edge after reset release, decode ready.
        drive(1'b1, 32'h0, 1'b1, 1'b0);
        bus.fetch_instr_i = 32'h0050_0093;
        #1;
        n_checks++; if (bus.dec_valid_o !== 1'b0) begin n_fail++; $display("FAIL single_no_fallthrough got=%b exp=0", bus.dec_valid_o); end
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        n_checks++; if (bus.dec_valid_o !== 1'b1) begin n_fail++; $display("FAIL single_dec_valid got=%b exp=1", bus.dec_valid_o); end
        n_checks++; if (bus.dec_pc_o !== 32'h0) begin n_fail++; $display("FAIL single_pc got=%h exp=%h", bus.dec_pc_o, 32'h0); end
        n_checks++; if (bus.dec_instr_o !== 32'h0050_0093) begin n_fail++; $display("FAIL single_instr got=%h exp=%h", bus.dec_instr_o, 32'h0050_0093); end
        n_checks++; if (count_o !== 3'd1) begin n_fail++; $display("FAIL single_count1 got=%0d exp=1", count_o); end
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        n_checks++; if (count_o !== 3'd0) begin n_fail++; $display("FAIL single_count0 got=%0d exp=0", count_o); end
        n_checks++; if (bus.dec_valid_o !== 1'b0) begin n_fail++; $display("FAIL single_dec_valid_after got=%b exp=0", bus.dec_valid_o); end
    endtask

    task automatic test_fill();
        logic [31:0] heads [3];
        heads[0] = 32'h8; heads[1] = 32'hC; heads[2] = 32'h10;
        // Four pushes with decode stalled; ready stays high until full.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'(4 * i), 1'b0, 1'b0);
            n_checks++; if (bus.fetch_ready_o !== 1'b1) begin n_fail++; $display("FAIL fill_ready_%0d got=%b exp=1", i, bus.fetch_ready_o); end
            n_checks++; if (count_o !== 3'(i)) begin n_fail++; $display("FAIL fill_count_%0d got=%0d exp=%0d", i, count_o, i); end
        end
        // Fifth entry presented while full: held off.
        drive(1'b1, 32'h10, 1'b0, 1'b0);
        n_checks++; if (bus.fetch_ready_o !== 1'b0) begin n_fail++; $display("FAIL fill_full_ready got=%b exp=0", bus.fetch_ready_o); end
        n_checks++; if (count_o !== 3'd4) begin n_fail++; $display("FAIL fill_full_count got=%0d exp=4", count_o); end
        n_checks++; if (bus.dec_pc_o !== 32'h0) begin n_fail++; $display("FAIL fill_stall_head got=%h exp=0", bus.dec_pc_o); end
        // Pop one while full; push still blocked this cycle.
        drive(1'b1, 32'h10, 1'b1, 1'b0);
        n_checks++; if (bus.fetch_ready_o !== 1'b0) begin n_fail++; $display("FAIL fill_pop_ready got=%b exp=0", bus.fetch_ready_o); end
        n_checks++; if (bus.dec_pc_o !== 32'h0) begin n_fail++; $display("FAIL fill_head0 got=%h exp=0", bus.dec_pc_o); end
        // Now 3 entries: fifth push accepted alongside a pop.
        drive(1'b1, 32'h10, 1'b1, 1'b0);
        n_checks++; if (bus.fetch_ready_o !== 1'b1) begin n_fail++; $display("FAIL fill_ready_again got=%b exp=1", bus.fetch_ready_o); end
        n_checks++; if (count_o !== 3'd3) begin n_fail++; $display("FAIL fill_count3 got=%0d exp=3", count_o); end
        n_checks++; if (bus.dec_pc_o !== 32'h4) begin n_fail++; $display("FAIL fill_head1 got=%h exp=4", bus.dec_pc_o); end
        // Drain the remainder in order.
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 32'h0, 1'b1, 1'b0);
            n_checks++; if (bus.dec_valid_o !== 1'b1 || bus.dec_pc_o !== heads[i]) begin n_fail++; $display("FAIL fill_drain_%0d got=%b/%h exp=1/%h", i, bus.dec_valid_o, bus.dec_pc_o, heads[i]); end
            n_checks++; if (bus.dec_instr_o !== instr_of(heads[i])) begin n_fail++; $display("FAIL fill_drain_instr_%0d got=%h exp=%h", i, bus.dec_instr_o, instr_of(heads[i])); end
            n_checks++; if (count_o !== 3'(3 - i)) begin n_fail++; $display("FAIL fill_drain_count_%0d got=%0d exp=%0d", i, count_o, 3 - i); end
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        n_checks++; if (count_o !== 3'd0) begin n_fail++; $display("FAIL fill_empty got=%0d exp=0", count_o); end
    endtask

    task automatic test_back_to_back();
        exp_q.delete();
        drive(1'b1, 32'h200, 1'b0, 1'b0); exp_q.push_back(32'h200);
        drive(1'b1, 32'h204, 1'b0, 1'b0); exp_q.push_back(32'h204);
        // 20 cycles of simultaneous push and pop: occupancy fixed at 2.
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 32'h208 + 32'(4 * i), 1'b1, 1'b0);
            exp_pc = exp_q.pop_front();
            exp_q.push_back(32'h208 + 32'(4 * i));
            n_checks++; if (count_o !== 3'd2) begin n_fail++; $display("FAIL b2b_count_%0d got=%0d exp=2", i, count_o); end
            n_checks++; if (bus.dec_valid_o !== 1'b1 || bus.dec_pc_o !== exp_pc) begin n_fail++; $display("FAIL b2b_head_%0d got=%b/%h exp=1/%h", i, bus.dec_valid_o, bus.dec_pc_o, exp_pc); end
            n_checks++; if (bus.dec_instr_o !== instr_of(exp_pc)) begin n_fail++; $display("FAIL b2b_instr_%0d got=%h exp=%h", i, bus.dec_instr_o, instr_of(exp_pc)); end
        end
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 32'h0, 1'b1, 1'b0);
            exp_pc = exp_q.pop_front();
            n_checks++; if (bus.dec_valid_o !== 1'b1 || bus.dec_pc_o !== exp_pc) begin n_fail++; $display("FAIL b2b_drain_%0d got=%b/%h exp=1/%h", i, bus.dec_valid_o, bus.dec_pc_o, exp_pc); end
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        n_checks++; if (count_o !== 3'd0) begin n_fail++; $display("FAIL b2b_empty got=%0d exp=0", count_o); end
    endtask

    task automatic test_flush();
        drive(1'b1, 32'h20, 1'b0, 1'b0);
        drive(1'b1, 32'h24, 1'b0, 1'b0);
        drive(1'b1, 32'h28, 1'b0, 1'b0);
        // Flush with a concurrent push and decode ready.
        drive(1'b1, 32'h40, 1'b1, 1'b1);
        n_checks++; if (bus.dec_valid_o !== 1'b0) begin n_fail++; $display("FAIL flush_dec_valid got=%b exp=0", bus.dec_valid_o); end
        n_checks++; if (count_o !== 3'd3) begin n_fail++; $display("FAIL flush_count_before got=%0d exp=3", count_o); end
        // Second consecutive flush, again with a push presented.
        drive(1'b1, 32'h44, 1'b1, 1'b1);
        n_checks++; if (count_o !== 3'd0) begin n_fail++; $display("FAIL flush_count_after got=%0d exp=0", count_o); end
        n_checks++; if (bus.dec_valid_o !== 1'b0) begin n_fail++; $display("FAIL flush2_dec_valid got=%b exp=0", bus.dec_valid_o); end
        // Flush released: new target accepted immediately.
        drive(1'b1, 32'h100, 1'b0, 1'b0);
        n_checks++; if (count_o !== 3'd0) begin n_fail++; $display("FAIL flush2_count got=%0d exp=0", count_o); end
        n_checks++; if (bus.fetch_ready_o !== 1'b1) begin n_fail++; $display("FAIL flush_ready got=%b exp=1", bus.fetch_ready_o); end
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        n_checks++; if (bus.dec_valid_o !== 1'b1 || bus.dec_pc_o !== 32'h100) begin n_fail++; $display("FAIL flush_first_after got=%b/%h exp=1/%h", bus.dec_valid_o, bus.dec_pc_o, 32'h100); end
        n_checks++; if (count_o !== 3'd1) begin n_fail++; $display("FAIL flush_count_new got=%0d exp=1", count_o); end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        n_checks++; if (count_o !== 3'd0 || bus.dec_valid_o !== 1'b0) begin n_fail++; $display("FAIL flush_no_stale got=%0d/%b exp=0/0", count_o, bus.dec_valid_o); end
    endtask

    task automatic test_misalign();
        drive(1'b1, 32'h6, 1'b0, 1'b0);
        drive(1'b1, 32'h8, 1'b0, 1'b0);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        n_checks++; if (bus.dec_pc_o !== 32'h6 || bus.dec_misalign_o !== 1'b1) begin n_fail++; $display("FAIL misalign_6 got=%h/%b exp=6/1", bus.dec_pc_o, bus.dec_misalign_o); end
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        n_checks++; if (bus.dec_pc_o !== 32'h8 || bus.dec_misalign_o !== 1'b0) begin n_fail++; $display("FAIL misalign_8 got=%h/%b exp=8/0", bus.dec_pc_o, bus.dec_misalign_o); end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        n_checks++; if (count_o !== 3'd0) begin n_fail++; $display("FAIL misalign_empty got=%0d exp=0", count_o); end
    endtask

    task automatic test_async_reset();
        drive(1'b1, 32'h300, 1'b0, 1'b0);
        drive(1'b1, 32'h304, 1'b0, 1'b0);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        n_checks++; if (count_o !== 3'd2) begin n_fail++; $display("FAIL areset_pre_count got=%0d exp=2", count_o); end
        // Pull reset between edges and look before the next rising edge.
        #1 rst_ni = 1'b0;
        #1;
        n_checks++; if (count_o !== 3'd0) begin n_fail++; $display("FAIL areset_count got=%0d exp=0", count_o); end
        n_checks++; if (bus.dec_valid_o !== 1'b0) begin n_fail++; $display("FAIL areset_dec_valid got=%b exp=0", bus.dec_valid_o); end
        n_checks++; if (bus.fetch_ready_o !== 1'b1) begin n_fail++; $display("FAIL areset_ready got=%b exp=1", bus.fetch_ready_o); end
        @(negedge clk_i);
        rst_ni = 1'b1;
        drive(1'b1, 32'h400, 1'b0, 1'b0);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        n_checks++; if (bus.dec_valid_o !== 1'b1 || bus.dec_pc_o !== 32'h400 || count_o !== 3'd1) begin n_fail++; $display("FAIL areset_resume got=%b/%h/%0d exp=1/%h/1", bus.dec_valid_o, bus.dec_pc_o, count_o, 32'h400); end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        n_checks          = 0;
        n_fail            = 0;
        rst_ni            = 1'b0;
        flush_i           = 1'b0;
        bus.fetch_valid_i = 1'b0;
        bus.fetch_pc_i    = '0;
        bus.fetch_instr_i = '0;
        bus.dec_ready_i   = 1'b0;

        test_reset();
        test_single();
        test_fill();
        test_back_to_back();
        test_flush();
        test_misalign();
        test_async_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch_buffer.md
INSTR_FETCH_BUFFER -- requirements
Module: instr_fetch_buffer

Interface
REQ-001 Parameter DEPTH, default 4, number of buffered fetch entries; the block SHALL support only powers of two from 2 to 16.
REQ-002 clk_i  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_ni  input  1  reset; asynchronous, active-low.
REQ-004 fetch_valid_i  input  1  fetch stage presents a fetched instruction.
REQ-005 fetch_pc_i  input  32  PC of the presented instruction.
REQ-006 fetch_instr_i  input  32  instruction word read from memory (RD).
REQ-007 fetch_ready_o  output  1  buffer can accept an entry this cycle.
REQ-008 flush_i  input  1  redirect (taken branch, JAL or JALR); discards all contents.
REQ-009 dec_valid_o  output  1  head entry is valid for decode.
REQ-010 dec_ready_i  input  1  decode consumes the head entry this cycle.
REQ-011 dec_pc_o  output  32  PC of the head entry.
REQ-012 dec_instr_o  output  32  instruction of the head entry.
REQ-013 dec_misalign_o  output  1  head entry PC has pc[1:0] != 0.
REQ-014 count_o  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-015 Push SHALL occur when fetch_valid_i && fetch_ready_o && !flush_i; pop SHALL occur when dec_valid_o && dec_ready_i.
REQ-016 fetch_ready_o SHALL equal (count == DEPTH) negated, derived from registered state only, with no combinational path from fetch_valid_i or dec_ready_i.
REQ-017 A pushed entry SHALL appear at dec_* no earlier than the cycle after acceptance; there is no fall-through path.
REQ-018 dec_valid_o SHALL equal (count != 0) && !flush_i.
REQ-019 When dec_valid_o is low, dec_pc_o, dec_instr_o and dec_misalign_o SHALL be don't-care.
REQ-020 Entries SHALL leave in acceptance order, and head fields SHALL remain stable while dec_valid_o && !dec_ready_i.
REQ-021 Simultaneous push and pop SHALL leave count unchanged and advance both pointers.
REQ-022 Simultaneous push and pop are impossible when full (ready low) and when empty (valid low).
REQ-023 Read and write pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH.
REQ-024 Full and empty SHALL be taken from count, not from pointer equality.
REQ-025 dec_misalign_o SHALL be computed at push from fetch_pc_i[1:0] and stored with the entry.
REQ-026 The buffer SHALL NOT filter misaligned entries.
REQ-027 flush_i SHALL have priority over push and pop.
REQ-028 In a flush cycle, any push SHALL be discarded and no pop SHALL occur.
REQ-029 On the next edge after a flush, count SHALL be 0 and both pointers SHALL be 0.
REQ-030 flush_i asserted on consecutive cycles SHALL keep the buffer empty.
REQ-031 The first push after a flush SHALL be accepted in the cycle after flush_i deasserts.

Reset
REQ-032 While rst_ni is low: count_o SHALL be 0, pointers 0, dec_valid_o 0 and fetch_ready_o 1.
REQ-033 Storage contents need no reset.
REQ-034 Reset asserted mid-operation SHALL discard all entries immediately, without waiting for a clock edge.
REQ-035 After reset release, the buffer SHALL accept a push on the first rising edge.

Structure
REQ-036 Package fetch_pkg SHALL hold typedef fetch_entry_t {pc[31:0], instr[31:0], misalign} and constant IFB_DEPTH_DEFAULT = 4.
REQ-037 Storage SHALL be an array of fetch_entry_t inside this module; no sub-module is warranted.
REQ-038 Target size is under 250 lines of RTL.

Verification
REQ-039 Reset then push PC 0x0/instr 0x00500093, dec_ready_i=1 -> dec_valid_o high exactly one cycle later with those values; count_o returns to 0.
REQ-040 Push 5 entries (PC 0x0..0x10) with dec_ready_i=0, DEPTH=4 -> fetch_ready_o low after 4th; 5th held until one pop; order preserved 0x0,0x4,0x8,0xC,0x10.
REQ-041 Steady push+pop every cycle for 20 cycles -> count_o constant, pointers wrap; no loss or duplication (scoreboard).
REQ-042 Three entries buffered, flush_i with concurrent push of PC 0x40 -> dec_valid_o low that cycle; count_o=0 next cycle; 0x40 never delivered; next push PC 0x100 delivered first.
REQ-043 Push PC 0x6 -> dec_misalign_o=1 on that entry only; PC 0x8 -> 0.
REQ-044 rst_ni pulled low between edges with 2 entries buffered -> count_o=0 and dec_valid_o=0 immediately, before the next clock edge.
